// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// State encodings are fixed so that state[1] alone gives the debounced level.
package switch_debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W         = 20;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
// Both stages reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    assign q = s2_reg;

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw asynchronous switch into a clean level plus a one-cycle
// rising-edge tick; a new value must hold for STABLE_CYCLES+1 synchronized samples.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STABLE_CYCLES - 1);

    logic             sw_sync;
    db_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             tick_reg, tick_next;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw),
        .q       (sw_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ZERO;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            tick_reg  <= tick_next;
        end
    end

    // A sample that disagrees with the pending value aborts the wait before
    // the counter is consulted, so a bounce on the final cycle is still rejected.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tick_next  = 1'b0;
        case (state_reg)
            ZERO: begin
                if (sw_sync) begin
                    state_next = WAIT1;
                    cnt_next   = LOAD_VAL;
                end
            end
            WAIT1: begin
                if (!sw_sync) begin
                    state_next = ZERO;
                end else if (cnt_reg == '0) begin
                    state_next = ONE;
                    tick_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ONE: begin
                if (!sw_sync) begin
                    state_next = WAIT0;
                    cnt_next   = LOAD_VAL;
                end
            end
            WAIT0: begin
                if (sw_sync) begin
                    state_next = ONE;
                end else if (cnt_reg == '0) begin
                    state_next = ZERO;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ZERO;
            end
        endcase
        level_next = (state_next == ONE) || (state_next == WAIT0);
    end

    assign db_level = level_reg;
    assign db_tick  = tick_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// Vector-table bench for switch_debounce: instance A uses STABLE_CYCLES=4,
// instance B uses STABLE_CYCLES=1; expectations are queued at drive time.
`timescale 1ns/1ps
module tb_switch_debounce;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sw_a = 1'b0;
    logic sw_b = 1'b0;
    logic level_a, tick_a, level_b, tick_b;

    always #5 clk = ~clk;

    switch_debounce #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw_a),
        .db_level (level_a),
        .db_tick  (tick_a)
    );

    switch_debounce #(
        .STABLE_CYCLES (1),
        .CNT_W         (1)
    ) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw_b),
        .db_level (level_b),
        .db_tick  (tick_b)
    );

    // sel=0 drives/checks instance A, sel=1 instance B; lvl/tick are the
    // outputs expected just after the edge that samples sw.
    typedef struct {
        logic sel;
        logic sw;
        logic lvl;
        logic tick;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic sel, input logic swv, input int n,
                                input logic lvl, input logic tick);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.sel  = sel;
            v.sw   = swv;
            v.lvl  = lvl;
            v.tick = tick;
            vecs.push_back(v);
        end
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        vec_t e;
        logic lv;
        logic tk;
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            if (vecs[i].sel) sw_b = vecs[i].sw;
            else             sw_a = vecs[i].sw;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            lv = e.sel ? level_b : level_a;
            tk = e.sel ? tick_b  : tick_a;
            $display("[TB] vec %0d dut %s sw=%b level=%b/%b tick=%b/%b",
                     i, e.sel ? "B" : "A", e.sw, lv, e.lvl, tk, e.tick);
            check($sformatf("vec%0d_level", i), lv, e.lvl);
            check($sformatf("vec%0d_tick", i), tk, e.tick);
        end
    endtask

    int n1, n2, n3;

    initial begin
        // Phase 1, instance A from reset (edge numbers in comments).
        add(0, 0, 9, 0, 0);                          // 1..9 idle
        add(0, 1, 6, 0, 0);                          // 10..15 clean press
        add(0, 1, 1, 1, 1);                          // 16 accepted, tick
        add(0, 1, 4, 1, 0);                          // 17..20
        add(0, 0, 3, 1, 0);                          // 21..23 release bounce
        add(0, 1, 4, 1, 0);                          // 24..27 back high
        add(0, 0, 6, 1, 0);                          // 28..33 real release
        add(0, 0, 4, 0, 0);                          // 34..37 fell, no tick
        add(0, 1, 1, 0, 0);                          // 38 bounce 1,0,1,1,0
        add(0, 0, 1, 0, 0);
        add(0, 1, 2, 0, 0);
        add(0, 0, 9, 0, 0);                          // 42..50
        add(0, 1, 4, 0, 0);                          // 51..54 four samples
        add(0, 0, 8, 0, 0);                          // 55..62 rejected
        add(0, 1, 5, 0, 0);                          // 63..67 five samples
        add(0, 0, 1, 0, 0);                          // 68
        add(0, 0, 1, 1, 1);                          // 69 accepted
        add(0, 0, 4, 1, 0);                          // 70..73
        add(0, 0, 7, 0, 0);                          // 74..80
        add(0, 1, 6, 0, 0);                          // 81..86
        add(0, 1, 1, 1, 1);                          // 87 tick, then reset
        n1 = vecs.size();
        // Phase 2, instance A after mid-operation reset with sw held high.
        add(0, 1, 6, 0, 0);
        add(0, 1, 1, 1, 1);
        add(0, 1, 3, 1, 0);
        n2 = vecs.size();
        // Phase 3, instance B with STABLE_CYCLES=1.
        add(1, 0, 3, 0, 0);                          // 1..3
        add(1, 1, 2, 0, 0);                          // 4..5 two samples
        add(1, 0, 1, 0, 0);                          // 6
        add(1, 0, 1, 1, 1);                          // 7 accepted
        add(1, 0, 1, 1, 0);                          // 8
        add(1, 0, 2, 0, 0);                          // 9..10 fell
        add(1, 1, 1, 0, 0);                          // 11 single sample
        add(1, 0, 6, 0, 0);                          // rejected
        n3 = vecs.size();

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level_a", level_a, 1'b0);
        check("reset_tick_a", tick_a, 1'b0);
        check("reset_level_b", level_b, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        apply(0, n1);

        // Asynchronous assert mid-cycle while the tick is high and sw is 1.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        $display("[TB] async reset: level=%b tick=%b", level_a, tick_a);
        check("async_reset_level", level_a, 1'b0);
        check("async_reset_tick", tick_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_level", level_a, 1'b0);
        #1;
        reset_n = 1'b1;

        apply(n1, n2);
        apply(n2, n3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
